// File: rtl/mux_scan_sequencer.sv
// Scanned reader for a 2**SEL_W:1 mux tree: steps the select through every channel,
// waits DWELL cycles per channel, samples the tree output and publishes a full word.
module mux_scan_sequencer #(
  parameter int SEL_W = 2,
  parameter int DWELL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  mux_out,
  output logic [SEL_W-1:0]      select_2,
  output logic [(1<<SEL_W)-1:0] data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int N     = 1 << SEL_W;
  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          sel_d   = '0;
          cnt_d   = CNT_INIT;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        shadow_d[sel_q] = mux_out;
        // The last channel goes straight into data_out so no partial word is ever visible
        if (sel_q == SEL_LAST) begin
          data_d  = {mux_out, shadow_q[N-2:0]};
          state_d = DONE;
        end else begin
          sel_d   = sel_q + 1'b1;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      DONE: begin
        sel_d = '0;
        if (continuous) begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign select_2 = sel_q;
  assign data_out = data_q;
  assign busy     = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: DWELL=2 instance for the main scans,
// DWELL=1 instance for the short-dwell case. Edge k = k-th rising edge after the reference edge.
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, cont_a, start_b, cont_b;
  logic [3:0] in_a, in_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] data_a, data_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic       mux_a, mux_b;

  assign mux_a = in_a[sel_a];
  assign mux_b = in_b[sel_b];

  mux_scan_sequencer #(.SEL_W(2), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .continuous(cont_a), .mux_out(mux_a),
    .select_2(sel_a), .data_out(data_a), .busy(busy_a), .done(done_a)
  );

  mux_scan_sequencer #(.SEL_W(2), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .continuous(cont_b), .mux_out(mux_b),
    .select_2(sel_b), .data_out(data_b), .busy(busy_b), .done(done_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: reset with every input asserted
    rst = 1'b1; start_a = 1'b1; cont_a = 1'b1; start_b = 1'b1; cont_b = 1'b1;
    in_a = 4'b1111; in_b = 4'b1111;
    tick(); tick();
    chk("t1_sel_a",  sel_a,  0);
    chk("t1_busy_a", busy_a, 0);
    chk("t1_done_a", done_a, 0);
    chk("t1_data_a", data_a, 0);
    chk("t1_sel_b",  sel_b,  0);
    chk("t1_busy_b", busy_b, 0);
    chk("t1_done_b", done_b, 0);
    chk("t1_data_b", data_b, 0);
    rst = 1'b0; start_a = 1'b0; cont_a = 1'b0; start_b = 1'b0; cont_b = 1'b0;
    tick();

    // Test 2: single scan of 4'b1101
    in_a = 4'b1101; start_a = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) start_a = 1'b0;
      chk($sformatf("t2_sel_e%0d", k), sel_a,
          (k <= 12) ? (k - 1) / 3 : ((k == 13) ? 3 : 0));
      chk($sformatf("t2_done_e%0d", k), done_a, (k == 13) ? 1 : 0);
      chk($sformatf("t2_busy_e%0d", k), busy_a, (k <= 12) ? 1 : 0);
      if (k == 12) chk("t2_data_pre", data_a, 0);
      if (k == 13) chk("t2_data", data_a, 4'b1101);
    end

    // Test 3: start re-pulsed mid-scan is ignored
    n_done = 0;
    start_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) start_a = 1'b0;
      if (k == 5) start_a = 1'b1;
      if (k == 6) start_a = 1'b0;
      if (done_a) n_done++;
      if (k == 13) chk("t3_done_e13", done_a, 1);
    end
    chk("t3_ndone", n_done, 1);
    chk("t3_idle_busy", busy_a, 0);
    chk("t3_idle_sel", sel_a, 0);
    chk("t3_data", data_a, 4'b1101);

    // Test 4: continuous scanning of 4'b1010
    in_a = 4'b1010; cont_a = 1'b1; start_a = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      tick();
      if (k == 1) start_a = 1'b0;
      chk($sformatf("t4_done_e%0d", k), done_a, (k % 13 == 0) ? 1 : 0);
      chk($sformatf("t4_busy_e%0d", k), busy_a, (k % 13 == 0) ? 0 : 1);
      if (k == 13 || k == 39) chk($sformatf("t4_data_e%0d", k), data_a, 4'b1010);
    end
    cont_a = 1'b0;
    tick();
    chk("t4_stop_busy", busy_a, 0);
    chk("t4_stop_done", done_a, 0);
    chk("t4_stop_sel", sel_a, 0);
    chk("t4_stop_data", data_a, 4'b1010);

    // Test 5: reset mid-scan
    in_a = 4'b1101; start_a = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) start_a = 1'b0;
    end
    chk("t5_sel_e7", sel_a, 2);
    rst = 1'b1;
    tick();
    chk("t5_sel", sel_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    chk("t5_data", data_a, 0);
    rst = 1'b0;
    n_done = 0;
    for (int k = 9; k <= 25; k++) begin
      tick();
      if (done_a) n_done++;
    end
    chk("t5_ndone", n_done, 0);
    chk("t5_busy_after", busy_a, 0);
    chk("t5_data_after", data_a, 0);

    // Test 6: DWELL=1 scan of 4'b0011
    in_b = 4'b0011; start_b = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) start_b = 1'b0;
      if (k <= 8) chk($sformatf("t6_sel_e%0d", k), sel_b, (k - 1) / 2);
      chk($sformatf("t6_done_e%0d", k), done_b, (k == 9) ? 1 : 0);
      if (k == 9) chk("t6_data", data_b, 4'b0011);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
